// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
  localparam int unsigned LANES        = 4;
  localparam int unsigned LANE_W       = $clog2(LANES);
  localparam int unsigned WORD_W       = 8 * LANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_word_pack.sv
// Byte-lane counter and little-endian packer: the first byte of a word ends up in word[7:0].
module imem_word_pack
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [LANE_W-1:0] cnt_q;

  // New bytes enter at the top, so after LANES shifts the oldest byte sits in the low lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      word  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (shift) begin
      cnt_q <= cnt_q + LANE_W'(1);
      word  <= {byte_in, word[WORD_W-1:8]};
    end
  end

  // High while the next accepted byte completes the word.
  assign word_full = (cnt_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset until an image lands.
// Build option: define LOADER_CSUM_EN to expect and verify a trailing XOR checksum byte.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WE,
  output logic [ADDR_W-1:0] WAddr,
  output logic [WORD_W-1:0] WData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Err
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [15:0] MAX_WORDS = 16'(1 << ADDR_W);

  state_t             state_q, state_d;
  logic               ready_d, we_d, hold_d, done_d, err_d;
  logic [ADDR_W-1:0]  waddr_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        len_n;
  logic               accept, pack_clr, pack_shift, word_full;
`ifdef LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign accept = ByteValid && ByteReady;
  assign len_n  = {ByteIn, len_lo_q};

  imem_word_pack u_pack (
    .clk       (Clk),
    .rst_n     (Rst),
    .clr       (pack_clr),
    .shift     (pack_shift),
    .byte_in   (ByteIn),
    .word      (WData),
    .word_full (word_full)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      ByteReady <= 1'b1;
      WE        <= 1'b0;
      WAddr     <= '0;
      left_q    <= '0;
      len_lo_q  <= '0;
      CpuHold   <= 1'b1;
      Done      <= 1'b0;
      Err       <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ByteReady <= ready_d;
      WE        <= we_d;
      WAddr     <= waddr_d;
      left_q    <= left_d;
      len_lo_q  <= len_lo_d;
      CpuHold   <= hold_d;
      Done      <= done_d;
      Err       <= err_d;
`ifdef LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = WAddr;
    left_d     = left_q;
    len_lo_d   = len_lo_q;
    hold_d     = CpuHold;
    done_d     = Done;
    err_d      = Err;
    pack_clr   = 1'b0;
    pack_shift = 1'b0;
`ifdef LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      // Idle and both terminal states share the restart-on-SYNC behaviour.
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && ByteIn == SYNC) begin
          state_d  = S_LEN_LO;
          done_d   = 1'b0;
          err_d    = 1'b0;
          hold_d   = 1'b1;
          waddr_d  = '0;
          pack_clr = 1'b1;
`ifdef LOADER_CSUM_EN
          csum_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = ByteIn;
          state_d  = S_LEN_HI;
`ifdef LOADER_CSUM_EN
          csum_d   = csum_q ^ ByteIn;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
`ifdef LOADER_CSUM_EN
          csum_d = csum_q ^ ByteIn;
`endif
          left_d = CNT_W'(len_n);
          if (len_n > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_n == 16'd0) begin
`ifdef LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
`ifdef LOADER_CSUM_EN
          csum_d     = csum_q ^ ByteIn;
`endif
          if (word_full) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
      end
      // Address advances only when another word follows, so it never wraps.
      S_WRITE: begin
        if (left_q == CNT_W'(1)) begin
`ifdef LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end else begin
          state_d = S_DATA;
          waddr_d = WAddr + ADDR_W'(1);
          left_d  = left_q - CNT_W'(1);
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (ByteIn == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d != S_WRITE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus write scoreboard; follows LOADER_CSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [7:0]        ByteIn = 8'h00;
  logic              ByteValid = 1'b0;
  logic              ByteReady, WE, CpuHold, Done, Err;
  logic [ADDR_W-1:0] WAddr;
  logic [31:0]       WData;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [15:0] len;
    logic [31:0] seed;
    bit          garbage;
    bit          bad_csum;
    bit          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t vecs[6];

  imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .WE        (WE),
    .WAddr     (WAddr),
    .WData     (WData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wgen(input logic [31:0] seed, input int i);
    return seed + (32'(i) * 32'h9E3779B9);
  endfunction

  // Write monitor: every WE cycle pops one expected write; ready must be the complement of WE.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("ready_vs_we", 32'(ByteReady), 32'(!WE));
      if (WE) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_we: WAddr=%0d WData=0x%08h expected no write", WAddr, WData);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("waddr", 32'(WAddr), 32'(e.addr));
          check("wdata", WData, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (!ByteReady && n < 8) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!ByteReady) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: ByteReady=0 expected 1 within 8 cycles");
    end
    @(posedge Clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(ByteReady), 32'd1);
    check({tag, "_we"},    32'(WE),        32'd0);
    check({tag, "_waddr"}, 32'(WAddr),     32'd0);
    check({tag, "_wdata"}, WData,          32'd0);
    check({tag, "_hold"},  32'(CpuHold),   32'd1);
    check({tag, "_done"},  32'(Done),      32'd0);
    check({tag, "_err"},   32'(Err),       32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [7:0]  b;
    wr_t         wr;
    if (v.garbage) begin
      send_byte(8'h00);
      send_byte(8'hFF);
    end
    send_byte(8'hA5);
    check("sync_done_low",  32'(Done),    32'd0);
    check("sync_err_low",   32'(Err),     32'd0);
    check("sync_hold_high", 32'(CpuHold), 32'd1);
    send_byte(v.len[7:0]);
    send_byte(v.len[15:8]);
    cs = v.len[7:0] ^ v.len[15:8];
    if (v.len <= 16'(DEPTH)) begin
      for (int i = 0; i < int'(v.len); i++) begin
        w = wgen(v.seed, i);
        for (int j = 0; j < 4; j++) begin
          b  = w[8*j +: 8];
          cs = cs ^ b;
          if (j == 3) begin
            wr.addr = ADDR_W'(i);
            wr.data = w;
            sb.push_back(wr);
          end
          send_byte(b);
        end
      end
`ifdef LOADER_CSUM_EN
      send_byte(v.bad_csum ? (cs ^ 8'hFF) : cs);
`else
      if (v.len != 16'd0) begin
        ByteValid = 1'b0;
        check("done_not_early", 32'(Done), 32'd0);
        @(posedge Clk); #1;
      end
`endif
    end
    ByteValid = 1'b0;
    check("frame_done", 32'(Done),    32'(v.exp_done));
    check("frame_err",  32'(Err),     32'(v.exp_err));
    check("frame_hold", 32'(CpuHold), 32'(!v.exp_done));
    check("sb_empty",   32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge Clk); #1;
  endtask

  initial begin
    vecs[0] = '{len: 16'd1,  seed: 32'hE3A00013, garbage: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 16'd0,  seed: 32'h0,        garbage: 1'b1, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 16'd3,  seed: 32'hE3A01005, garbage: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{len: 16'd3,  seed: 32'hE3A01005, garbage: 1'b0, bad_csum: 1'b1, exp_done: !CSUM_EN, exp_err: CSUM_EN};
    vecs[4] = '{len: 16'd65, seed: 32'h0,        garbage: 1'b1, bad_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{len: 16'd64, seed: 32'h12345678, garbage: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    #2 Rst = 1'b0;
    #20;
    check_reset("por");
    Rst    = 1'b1;
    mon_en = 1'b1;
    @(posedge Clk); #1;

    for (int k = 0; k < 6; k++) run_frame(vecs[k]);

    // Reset in the middle of the second word of a two-word frame.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    begin
      logic [31:0] w0;
      wr_t         wr;
      w0 = 32'hDEADBEEF;
      wr.addr = '0;
      wr.data = w0;
      for (int j = 0; j < 4; j++) begin
        if (j == 3) sb.push_back(wr);
        send_byte(w0[8*j +: 8]);
      end
    end
    send_byte(8'h11);
    send_byte(8'h22);
    ByteValid = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check_reset("midrst");
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    run_frame(vecs[0]);

    repeat (3) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
